// File: rtl/pc_fetch_if.sv
// pc_fetch_if: fetch-stage bus bundling redirect inputs, instruction memory
// port and the IF/ID register outputs.
//   master : the fetch unit (drives inst_addr and the IF/ID outputs)
//   slave  : the surrounding pipeline / memory (drives stall, redirects, inst_in)
interface pc_fetch_if;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic [5:0]  inst_addr;
  logic [31:0] inst_in;
  logic [31:0] instr_out;
  logic [31:0] pc4_out;
  logic        valid_out;
  logic [15:0] fetch_count;
  logic        addr_err;

  modport master (
    input  stall, branch_taken, branch_offset, jump, jump_target, inst_in,
    output inst_addr, instr_out, pc4_out, valid_out, fetch_count, addr_err
  );

  modport slave (
    output stall, branch_taken, branch_offset, jump, jump_target, inst_in,
    input  inst_addr, instr_out, pc4_out, valid_out, fetch_count, addr_err
  );
endinterface

// File: rtl/pc_fetch.sv
// pc_fetch: program counter and IF/ID register for a 64-word instruction
// memory. Next PC priority is jump > branch > sequential; redirects override
// stall and insert a bubble into IF/ID.
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   fetch_bus pc_fetch_if.master (redirect inputs, memory port, IF/ID outputs)
// Parameter:
//   RESET_PC  PC loaded on reset (word aligned)
// Optional feature:
//   PC_FETCH_RANGE_CHK_EN  when defined, a next PC >= 32'h100 sets the sticky
//   addr_err flag, holds the PC and halts fetching until reset. When
//   undefined, addr_err is 0 and the memory address simply wraps.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst_n,
  pc_fetch_if.master fetch_bus
);

  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 16;

  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  r_pc4;
  logic [31:0]      r_instr;
  logic             r_valid;
  logic [CNT_W-1:0] r_count;

  logic [PC_W-1:0]  w_seq_pc;
  logic [PC_W-1:0]  w_jump_pc;
  logic [PC_W-1:0]  w_branch_pc;
  logic [PC_W-1:0]  w_next_pc;
  logic [PC_W-1:0]  w_br_off;
  logic             w_redirect;
  logic             w_advance;
  logic             w_oor;
  logic             w_halted;

  // Target computation; branch offset is relative to the IF/ID PC+4.
  assign w_seq_pc    = r_pc + PC_W'(4);
  assign w_jump_pc   = {r_pc4[31:28], fetch_bus.jump_target, 2'b00};
  assign w_br_off    = {{14{fetch_bus.branch_offset[15]}}, fetch_bus.branch_offset, 2'b00};
  assign w_branch_pc = r_pc4 + w_br_off;
  assign w_redirect  = fetch_bus.jump | fetch_bus.branch_taken;
  assign w_advance   = w_redirect | ~fetch_bus.stall;

  always_comb begin
    w_next_pc = w_seq_pc;
    if (fetch_bus.jump)              w_next_pc = w_jump_pc;
    else if (fetch_bus.branch_taken) w_next_pc = w_branch_pc;
  end

`ifdef PC_FETCH_RANGE_CHK_EN
  localparam logic [PC_W-1:0] PC_LIMIT = 32'h0000_0100;
  logic r_addr_err;

  assign w_oor    = w_advance & ~r_addr_err & (w_next_pc >= PC_LIMIT);
  assign w_halted = r_addr_err;

  // Sticky out-of-range flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_addr_err <= 1'b0;
    else if (w_oor) r_addr_err <= 1'b1;
  end
`else
  assign w_oor    = 1'b0;
  assign w_halted = 1'b0;
`endif

  // PC and IF/ID register; once halted by a range error everything holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_pc4   <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
    end else if (!w_halted) begin
      if (w_oor) begin
        r_instr <= '0;
        r_valid <= 1'b0;
      end else if (w_redirect) begin
        r_pc    <= w_next_pc;
        r_instr <= '0;
        r_valid <= 1'b0;
      end else if (!fetch_bus.stall) begin
        r_pc    <= w_seq_pc;
        r_pc4   <= w_seq_pc;
        r_instr <= fetch_bus.inst_in;
        r_valid <= 1'b1;
        if (r_count != {CNT_W{1'b1}}) r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign fetch_bus.inst_addr   = r_pc[7:2];
  assign fetch_bus.instr_out   = r_instr;
  assign fetch_bus.pc4_out     = r_pc4;
  assign fetch_bus.valid_out   = r_valid;
  assign fetch_bus.fetch_count = r_count;
`ifdef PC_FETCH_RANGE_CHK_EN
  assign fetch_bus.addr_err    = r_addr_err;
`else
  assign fetch_bus.addr_err    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed test of pc_fetch with an instruction memory whose
// word n holds the value n.
module tb_pc_fetch;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  pc_fetch_if bus();

  pc_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_bus (bus)
  );

  // Instruction memory: word n = n.
  assign bus.inst_in = 32'(bus.inst_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_offset = 16'h0;
    bus.jump = 1'b0; bus.jump_target = 26'h0;
    #2;
    n_cmp++; if (bus.inst_addr !== 6'd0) begin n_bad++; $display("FAIL reset_inst_addr: got %0d want 0", bus.inst_addr); end
    n_cmp++; if (bus.instr_out !== 32'h0) begin n_bad++; $display("FAIL reset_instr_out: got %h want 0", bus.instr_out); end
    n_cmp++; if (bus.pc4_out !== 32'h0) begin n_bad++; $display("FAIL reset_pc4_out: got %h want 0", bus.pc4_out); end
    n_cmp++; if (bus.valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.valid_out); end
    n_cmp++; if (bus.fetch_count !== 16'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", bus.fetch_count); end
    n_cmp++; if (bus.addr_err !== 1'b0) begin n_bad++; $display("FAIL reset_addr_err: got %b want 0", bus.addr_err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    logic [5:0]  exp_addr [4] = '{6'd1, 6'd2, 6'd3, 6'd4};
    logic [31:0] exp_ins  [4] = '{32'd0, 32'd1, 32'd2, 32'd3};
    logic [31:0] exp_pc4  [4] = '{32'd4, 32'd8, 32'd12, 32'd16};
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++; if (bus.inst_addr !== exp_addr[k]) begin n_bad++; $display("FAIL seq_inst_addr[%0d]: got %0d want %0d", k, bus.inst_addr, exp_addr[k]); end
      n_cmp++; if (bus.instr_out !== exp_ins[k]) begin n_bad++; $display("FAIL seq_instr_out[%0d]: got %h want %h", k, bus.instr_out, exp_ins[k]); end
      n_cmp++; if (bus.pc4_out !== exp_pc4[k]) begin n_bad++; $display("FAIL seq_pc4_out[%0d]: got %h want %h", k, bus.pc4_out, exp_pc4[k]); end
      n_cmp++; if (bus.valid_out !== 1'b1) begin n_bad++; $display("FAIL seq_valid[%0d]: got %b want 1", k, bus.valid_out); end
    end
    n_cmp++; if (bus.fetch_count !== 16'd4) begin n_bad++; $display("FAIL seq_count: got %0d want 4", bus.fetch_count); end
  endtask

  task automatic test_stall();
    do_reset();
    step();
    step();
    // pc = 8, instr_out = 1, pc4_out = 8, count = 2
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (bus.inst_addr !== 6'd2) begin n_bad++; $display("FAIL stall_inst_addr[%0d]: got %0d want 2", k, bus.inst_addr); end
      n_cmp++; if (bus.instr_out !== 32'd1) begin n_bad++; $display("FAIL stall_instr_out[%0d]: got %h want 1", k, bus.instr_out); end
      n_cmp++; if (bus.pc4_out !== 32'd8) begin n_bad++; $display("FAIL stall_pc4_out[%0d]: got %h want 8", k, bus.pc4_out); end
      n_cmp++; if (bus.valid_out !== 1'b1) begin n_bad++; $display("FAIL stall_valid[%0d]: got %b want 1", k, bus.valid_out); end
      n_cmp++; if (bus.fetch_count !== 16'd2) begin n_bad++; $display("FAIL stall_count[%0d]: got %0d want 2", k, bus.fetch_count); end
    end
    bus.stall = 1'b0;
    step();
    n_cmp++; if (bus.instr_out !== 32'd2) begin n_bad++; $display("FAIL resume_instr_out: got %h want 2", bus.instr_out); end
    n_cmp++; if (bus.inst_addr !== 6'd3) begin n_bad++; $display("FAIL resume_inst_addr: got %0d want 3", bus.inst_addr); end
    n_cmp++; if (bus.pc4_out !== 32'd12) begin n_bad++; $display("FAIL resume_pc4_out: got %h want c", bus.pc4_out); end
    n_cmp++; if (bus.fetch_count !== 16'd3) begin n_bad++; $display("FAIL resume_count: got %0d want 3", bus.fetch_count); end
  endtask

  task automatic test_branch();
    step();
    // pc = 16, pc4_out = 16, instr_out = 3, count = 4
    n_cmp++; if (bus.pc4_out !== 32'h10) begin n_bad++; $display("FAIL br_pre_pc4: got %h want 10", bus.pc4_out); end
    bus.branch_taken = 1'b1;
    bus.branch_offset = 16'hFFFE;
    step();
    bus.branch_taken = 1'b0;
    bus.branch_offset = 16'h0;
    n_cmp++; if (bus.inst_addr !== 6'd2) begin n_bad++; $display("FAIL br_inst_addr: got %0d want 2", bus.inst_addr); end
    n_cmp++; if (bus.valid_out !== 1'b0) begin n_bad++; $display("FAIL br_valid: got %b want 0", bus.valid_out); end
    n_cmp++; if (bus.instr_out !== 32'h0) begin n_bad++; $display("FAIL br_instr_out: got %h want 0", bus.instr_out); end
    n_cmp++; if (bus.pc4_out !== 32'h10) begin n_bad++; $display("FAIL br_pc4_hold: got %h want 10", bus.pc4_out); end
    n_cmp++; if (bus.fetch_count !== 16'd4) begin n_bad++; $display("FAIL br_count: got %0d want 4", bus.fetch_count); end
    step();
    n_cmp++; if (bus.instr_out !== 32'd2) begin n_bad++; $display("FAIL br_target_instr: got %h want 2", bus.instr_out); end
    n_cmp++; if (bus.pc4_out !== 32'hC) begin n_bad++; $display("FAIL br_target_pc4: got %h want c", bus.pc4_out); end
    n_cmp++; if (bus.fetch_count !== 16'd5) begin n_bad++; $display("FAIL br_target_count: got %0d want 5", bus.fetch_count); end
  endtask

  task automatic test_jump_priority();
    // pc = 12, pc4_out = 12
    bus.stall = 1'b1;
    bus.jump = 1'b1;
    bus.jump_target = 26'h20;
    bus.branch_taken = 1'b1;
    bus.branch_offset = 16'h0004;
    step();
    bus.jump = 1'b0;
    bus.branch_taken = 1'b0;
    n_cmp++; if (bus.inst_addr !== 6'h20) begin n_bad++; $display("FAIL jmp_inst_addr: got %h want 20", bus.inst_addr); end
    n_cmp++; if (bus.valid_out !== 1'b0) begin n_bad++; $display("FAIL jmp_valid: got %b want 0", bus.valid_out); end
    n_cmp++; if (bus.instr_out !== 32'h0) begin n_bad++; $display("FAIL jmp_instr_out: got %h want 0", bus.instr_out); end
    n_cmp++; if (bus.pc4_out !== 32'hC) begin n_bad++; $display("FAIL jmp_pc4_hold: got %h want c", bus.pc4_out); end
    step();
    n_cmp++; if (bus.inst_addr !== 6'h20) begin n_bad++; $display("FAIL jmp_stall_addr: got %h want 20", bus.inst_addr); end
    n_cmp++; if (bus.valid_out !== 1'b0) begin n_bad++; $display("FAIL jmp_stall_bubble: got %b want 0", bus.valid_out); end
    bus.stall = 1'b0;
    step();
    n_cmp++; if (bus.instr_out !== 32'h20) begin n_bad++; $display("FAIL jmp_fetch_instr: got %h want 20", bus.instr_out); end
    n_cmp++; if (bus.pc4_out !== 32'h84) begin n_bad++; $display("FAIL jmp_fetch_pc4: got %h want 84", bus.pc4_out); end
    n_cmp++; if (bus.valid_out !== 1'b1) begin n_bad++; $display("FAIL jmp_fetch_valid: got %b want 1", bus.valid_out); end
  endtask

  task automatic test_wrap();
    // Jump to 32'hFC, then fetch sequentially past the top of memory.
    bus.jump = 1'b1;
    bus.jump_target = 26'h3F;
    step();
    bus.jump = 1'b0;
    n_cmp++; if (bus.inst_addr !== 6'h3F) begin n_bad++; $display("FAIL wrap_at_fc: got %h want 3f", bus.inst_addr); end
    step();
`ifdef PC_FETCH_RANGE_CHK_EN
    n_cmp++; if (bus.addr_err !== 1'b1) begin n_bad++; $display("FAIL wrap_addr_err: got %b want 1", bus.addr_err); end
    n_cmp++; if (bus.inst_addr !== 6'h3F) begin n_bad++; $display("FAIL wrap_pc_hold: got %h want 3f", bus.inst_addr); end
    n_cmp++; if (bus.valid_out !== 1'b0) begin n_bad++; $display("FAIL wrap_valid: got %b want 0", bus.valid_out); end
    step();
    n_cmp++; if (bus.valid_out !== 1'b0) begin n_bad++; $display("FAIL wrap_suppressed: got %b want 0", bus.valid_out); end
    n_cmp++; if (bus.addr_err !== 1'b1) begin n_bad++; $display("FAIL wrap_sticky: got %b want 1", bus.addr_err); end
`else
    n_cmp++; if (bus.inst_addr !== 6'd0) begin n_bad++; $display("FAIL wrap_inst_addr: got %h want 0", bus.inst_addr); end
    n_cmp++; if (bus.pc4_out !== 32'h100) begin n_bad++; $display("FAIL wrap_pc4: got %h want 100", bus.pc4_out); end
    n_cmp++; if (bus.instr_out !== 32'h3F) begin n_bad++; $display("FAIL wrap_instr: got %h want 3f", bus.instr_out); end
    n_cmp++; if (bus.addr_err !== 1'b0) begin n_bad++; $display("FAIL wrap_addr_err: got %b want 0", bus.addr_err); end
    step();
    n_cmp++; if (bus.pc4_out !== 32'h104) begin n_bad++; $display("FAIL wrap_pc_100: got %h want 104", bus.pc4_out); end
    n_cmp++; if (bus.instr_out !== 32'h0) begin n_bad++; $display("FAIL wrap_mem0: got %h want 0", bus.instr_out); end
`endif
  endtask

  task automatic test_async_reset();
    bus.branch_taken = 1'b1;
    bus.branch_offset = 16'h0010;
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.inst_addr !== 6'd0) begin n_bad++; $display("FAIL areset_inst_addr: got %h want 0", bus.inst_addr); end
    n_cmp++; if (bus.instr_out !== 32'h0) begin n_bad++; $display("FAIL areset_instr: got %h want 0", bus.instr_out); end
    n_cmp++; if (bus.pc4_out !== 32'h0) begin n_bad++; $display("FAIL areset_pc4: got %h want 0", bus.pc4_out); end
    n_cmp++; if (bus.valid_out !== 1'b0) begin n_bad++; $display("FAIL areset_valid: got %b want 0", bus.valid_out); end
    n_cmp++; if (bus.fetch_count !== 16'd0) begin n_bad++; $display("FAIL areset_count: got %0d want 0", bus.fetch_count); end
    n_cmp++; if (bus.addr_err !== 1'b0) begin n_bad++; $display("FAIL areset_addr_err: got %b want 0", bus.addr_err); end
    bus.branch_taken = 1'b0;
    bus.branch_offset = 16'h0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_cmp++; if (bus.instr_out !== 32'h0) begin n_bad++; $display("FAIL post_reset_instr: got %h want 0", bus.instr_out); end
    n_cmp++; if (bus.valid_out !== 1'b1) begin n_bad++; $display("FAIL post_reset_valid: got %b want 1", bus.valid_out); end
    n_cmp++; if (bus.pc4_out !== 32'h4) begin n_bad++; $display("FAIL post_reset_pc4: got %h want 4", bus.pc4_out); end
    n_cmp++; if (bus.inst_addr !== 6'd1) begin n_bad++; $display("FAIL post_reset_addr: got %h want 1", bus.inst_addr); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_jump_priority();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
